fetch_unpacker: RTL and testbench
=================================

Name: fetch_unpacker

Overview:
- Consumer-side partner of the fetch-packet FIFO.
- Pops multi-lane fetch packets from the FIFO's pop port (empty / pop / pop_data) and issues them to decode one instruction per cycle, in lane order.
- Uses a valid/ready handshake towards decode and skips invalid lanes.
- Sits between the fetch queue and the decoder; honours pipeline flush.

Parameters:
- LANES, 2, instruction lanes per packet (power of two, 1..4).
- PC_WIDTH, 32, PC width per lane.
- INST_WIDTH, 32, instruction width per lane.
- PKT_WIDTH, LANES*(1+PC_WIDTH+INST_WIDTH), FIFO entry width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- flush  in  1  pipeline flush; drops all held state.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  PKT_WIDTH  FIFO head entry, valid when fifo_empty=0. Lane i occupies bits [i*L+L-1 : i*L], L=1+PC_WIDTH+INST_WIDTH, packed as {valid, pc, inst}.
- fifo_pop  out  1  dequeue request; FIFO head advances at the next edge.
- out_valid  out  1  instruction presented to decode.
- out_ready  in  1  decode accepts.
- out_pc  out  PC_WIDTH  PC of presented instruction.
- out_inst  out  INST_WIDTH  presented instruction.

Behaviour:
- State:
  - held (1b): packet register occupied.
  - pkt (PKT_WIDTH): held packet.
  - idx (clog2(LANES), min 1b): current lane.
- Invariant: whenever held=1, pkt lane idx is valid.
- Reset (rst=0 at edge):
  - held=0, idx=0, pkt=0.
  - fifo_pop forced 0 combinationally while rst=0.
  - Outputs during reset: out_valid=0, out_pc=0, out_inst=0.
- Outputs (combinational from state):
  - out_valid = held.
  - out_pc / out_inst = lane idx fields of pkt.
  - When held=0, out_pc and out_inst are 0.
- fire = out_valid & out_ready.
- last = fire and no valid lane above idx in pkt.
- fifo_pop = rst & ~flush & ~fifo_empty & (~held | last). Combinational.
- On an edge where fifo_pop=1:
  - pkt <= fifo_data.
  - If fifo_data has any valid lane: held <= 1, idx <= lowest valid lane.
  - If no lane is valid: held <= 0 (packet silently dropped; pop may reissue next cycle).
- On fire & ~last: idx <= next valid lane above idx (skip invalid lanes); held stays 1.
- On last with no pop: held <= 0.
- On last with pop (simultaneous): load the new packet as above. Yields back-to-back issue with no bubble.
- Stall (held & ~out_ready): all state and outputs hold. out_valid must not drop and data must not change until fire (AXI-style stability).
- flush=1 at edge (rst=1): held <= 0, idx <= 0. fifo_pop=0 that cycle. Any fire in that cycle is still seen by decode, but decode discards it per flush.
- Priority: rst > flush > pop-load > advance.
- Throughput: 1 instruction/cycle sustained when the FIFO is non-empty and out_ready=1.
- Latency: FIFO non-empty with held=0 at cycle N → out_valid=1 in cycle N+1.

Optional Feature:
- Macro FETCH_UNPACKER_PERF_EN.
- Defined:
  - Adds ports perf_stall_cnt (out, 32) and perf_starve_cnt (out, 32).
  - perf_stall_cnt increments each cycle out_valid & ~out_ready.
  - perf_starve_cnt increments each cycle ~held & fifo_empty & rst & ~flush.
  - Both counters wrap at 2^32. Reset to 0 by rst=0 only; flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fetch_unpacker_pkg:
  - Lane-width constant L.
  - Field offsets VALID_BIT, PC_LSB, INST_LSB.
  - Lane typedef {valid, pc, inst}.
  - Function lowest_valid(mask, from) returning {found, index}.
- One sub-module: lane_select. Combinational priority encoder giving the first valid lane at or above a start index. Instantiated twice: load path (start 0) and advance path (start idx+1).

Test Plan:
- Reset then fifo_data with both lanes valid (pc 0x1C000000 / 0x1C000004, inst 0x02800000 / 0x02800400), out_ready=1 → fifo_pop=1 cycle 1; out 0x1C000000 cycle 2, 0x1C000004 cycle 3, next pop coincident with cycle 3.
- Packet with lane0 invalid, lane1 valid pc 0x1C000014 → single issue of 0x1C000014, idx=1 on load. All-invalid packet → popped, out_valid stays 0.
- out_ready=0 for 5 cycles while held → out_valid=1, out_pc/out_inst unchanged, fifo_pop=0; perf_stall_cnt=5 when FETCH_UNPACKER_PERF_EN is defined.
- Three full packets queued, out_ready=1 constantly → 6 consecutive out_valid cycles, no bubble, PCs strictly in order.
- flush asserted while lane0 held and FIFO non-empty → next cycle out_valid=0, fifo_pop=0 during flush cycle; resumes popping the cycle after.
- rst=0 asserted mid-stall → next cycle held=0, out_valid=0, fifo_pop=0 while rst=0; counters cleared.

Source files
------------

// File: rtl/fetch_unpacker_pkg.sv
// Shared lane layout and lane-search helper for the fetch unpacker.
// Lane packing inside a FIFO entry is {valid, pc, inst}, lane 0 in the low bits.
package fetch_unpacker_pkg;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned L         = 1 + PC_W + INST_W;
  localparam int unsigned VALID_BIT = L - 1;
  localparam int unsigned PC_LSB    = INST_W;
  localparam int unsigned INST_LSB  = 0;
  localparam int unsigned MAX_LANES = 4;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } lane_t;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  // A 'from' of 4 (one past the last lane) yields found=0.
  function automatic logic [2:0] lowest_valid(input logic [MAX_LANES-1:0] mask,
                                              input logic [2:0] from);
    logic [2:0] res;
    res = '0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/fetch_unpacker_lane_select.sv
// Combinational priority encoder: first valid lane at or above a start index.
module fetch_unpacker_lane_select
  import fetch_unpacker_pkg::*;
#(
  parameter int unsigned LANES = 2,
  localparam int unsigned IW   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] i_mask,
  input  logic [IW:0]      i_from,
  output logic             o_found_c,
  output logic [IW-1:0]    o_idx_c
);

  logic [2:0] w_res;

  assign w_res     = lowest_valid(MAX_LANES'(i_mask), 3'(i_from));
  assign o_found_c = w_res[2];
  assign o_idx_c   = IW'(w_res[1:0]);

endmodule

// File: rtl/fetch_unpacker.sv
// Pops multi-lane fetch packets from the fetch FIFO and issues one valid lane
// per cycle to decode over valid/ready. Optional counters: FETCH_UNPACKER_PERF_EN.
module fetch_unpacker
  import fetch_unpacker_pkg::*;
#(
  parameter int unsigned  LANES      = 2,
  parameter int unsigned  PC_WIDTH   = PC_W,
  parameter int unsigned  INST_WIDTH = INST_W,
  localparam int unsigned PKT_WIDTH  = LANES * (1 + PC_WIDTH + INST_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [PKT_WIDTH-1:0]  fifo_data,
  output logic                  fifo_pop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [INST_WIDTH-1:0] out_inst
`ifdef FETCH_UNPACKER_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_starve_cnt
`endif
);

  localparam int unsigned LW    = 1 + PC_WIDTH + INST_WIDTH;
  localparam int unsigned VB    = PC_WIDTH + INST_WIDTH;
  localparam int unsigned PCL   = INST_WIDTH;
  localparam int unsigned IW    = (LANES > 1) ? $clog2(LANES) : 1;

  logic                 r_held;
  logic [PKT_WIDTH-1:0] r_pkt;
  logic [IW-1:0]        r_idx;

  logic [LANES-1:0]     w_pkt_mask;
  logic [LANES-1:0]     w_load_mask;
  logic [LW-1:0]        w_lane [LANES];
  logic [LW-1:0]        w_cur;
  logic                 w_load_found;
  logic [IW-1:0]        w_load_idx;
  logic                 w_adv_found;
  logic [IW-1:0]        w_adv_idx;
  logic [IW:0]          w_adv_from;
  logic                 w_fire;
  logic                 w_last;
  logic                 w_show;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane[g]      = r_pkt[g*LW +: LW];
    assign w_pkt_mask[g]  = r_pkt[g*LW + VB];
    assign w_load_mask[g] = fifo_data[g*LW + VB];
  end

  fetch_unpacker_lane_select #(.LANES(LANES)) u_load_sel (
    .i_mask    (w_load_mask),
    .i_from    ('0),
    .o_found_c (w_load_found),
    .o_idx_c   (w_load_idx)
  );

  assign w_adv_from = (IW+1)'(r_idx) + (IW+1)'(1);

  fetch_unpacker_lane_select #(.LANES(LANES)) u_adv_sel (
    .i_mask    (w_pkt_mask),
    .i_from    (w_adv_from),
    .o_found_c (w_adv_found),
    .o_idx_c   (w_adv_idx)
  );

  // Presentation is suppressed while reset is asserted, even before the edge.
  assign w_show    = r_held & rst;
  assign w_cur     = w_lane[r_idx];
  assign out_valid = w_show;
  assign out_pc    = w_show ? w_cur[PCL +: PC_WIDTH] : '0;
  assign out_inst  = w_show ? w_cur[0 +: INST_WIDTH] : '0;

  assign w_fire   = out_valid & out_ready;
  assign w_last   = w_fire & ~w_adv_found;
  assign fifo_pop = rst & ~flush & ~fifo_empty & (~r_held | w_last);

  // Packet register: reset > flush > pop-load > lane advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_held <= 1'b0;
      r_idx  <= '0;
      r_pkt  <= '0;
    end else if (flush) begin
      r_held <= 1'b0;
      r_idx  <= '0;
    end else if (fifo_pop) begin
      r_pkt  <= fifo_data;
      r_held <= w_load_found;
      r_idx  <= w_load_found ? w_load_idx : '0;
    end else if (w_fire) begin
      if (w_last) r_held <= 1'b0;
      else        r_idx  <= w_adv_idx;
    end
  end

`ifdef FETCH_UNPACKER_PERF_EN
  // Free-running wrap-around counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cnt  <= '0;
      perf_starve_cnt <= '0;
    end else begin
      if (out_valid & ~out_ready)         perf_stall_cnt  <= perf_stall_cnt + 32'd1;
      if (~r_held & fifo_empty & ~flush)  perf_starve_cnt <= perf_starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unpacker.sv
// Directed, table-driven bench for fetch_unpacker with a queue-based FIFO model.
module tb_fetch_unpacker;
  import fetch_unpacker_pkg::*;

  localparam int unsigned PKTW = 2 * L;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            fifo_empty;
  logic [PKTW-1:0] fifo_data;
  logic            fifo_pop;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_pc;
  logic [31:0]     out_inst;
`ifdef FETCH_UNPACKER_PERF_EN
  logic [31:0]     perf_stall_cnt;
  logic [31:0]     perf_starve_cnt;
`endif

  fetch_unpacker #(.LANES(2), .PC_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst)
`ifdef FETCH_UNPACKER_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_starve_cnt (perf_starve_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [PKTW-1:0] q[$];
  logic [PKTW-1:0] pkts [5];

  typedef struct {
    logic        r;
    logic        f;
    logic        rdy;
    int          push;
    logic        exp_pop;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vt [7];

  function automatic logic [PKTW-1:0] mk(input logic v0, input logic [31:0] pc0, input logic [31:0] i0,
                                         input logic v1, input logic [31:0] pc1, input logic [31:0] i1);
    lane_t l0;
    lane_t l1;
    l0 = '{valid: v0, pc: pc0, inst: i0};
    l1 = '{valid: v1, pc: pc1, inst: i1};
    return {l1, l0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs for this cycle; outputs are sampled 1ns later, mid low phase.
  task automatic drive(input logic r, input logic f, input logic rdy);
    rst        = r;
    flush      = f;
    out_ready  = rdy;
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() == 0) ? '0 : q[0];
    #1;
  endtask

  task automatic advance();
    logic p;
    p = fifo_pop;
    @(posedge clk);
    if (p && q.size() > 0) void'(q.pop_front());
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".pc"},    64'(out_pc),    64'(pc));
    check({tag, ".inst"},  64'(out_inst),  64'(ins));
  endtask

  initial begin
    pkts[0] = mk(1'b1, 32'h1C000000, 32'h02800000, 1'b1, 32'h1C000004, 32'h02800400);
    pkts[1] = mk(1'b0, 32'h1C000010, 32'h0000DEAD, 1'b1, 32'h1C000014, 32'h02800C00);
    pkts[2] = mk(1'b0, 32'h1C000018, 32'h11111111, 1'b0, 32'h1C00001C, 32'h22222222);
    pkts[3] = mk(1'b1, 32'h1C000020, 32'h00000011, 1'b1, 32'h1C000024, 32'h00000012);
    pkts[4] = mk(1'b1, 32'h1C000030, 32'h00000021, 1'b1, 32'h1C000034, 32'h00000022);

    //          r     f     rdy   push pop   valid pc            inst
    vt[0] = '{1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[1] = '{1'b1, 1'b0, 1'b1,  0, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[2] = '{1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, 32'h1C000000, 32'h02800000};
    vt[3] = '{1'b1, 1'b0, 1'b1,  1, 1'b1, 1'b1, 32'h1C000004, 32'h02800400};
    vt[4] = '{1'b1, 1'b0, 1'b1,  2, 1'b1, 1'b1, 32'h1C000014, 32'h02800C00};
    vt[5] = '{1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[6] = '{1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0, 32'h0,        32'h0};

    rst = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    @(negedge clk);

    // Basic issue order, invalid-lane skip, all-invalid drop.
    for (int i = 0; i < 7; i++) begin
      if (vt[i].push >= 0) q.push_back(pkts[vt[i].push]);
      drive(vt[i].r, vt[i].f, vt[i].rdy);
      check($sformatf("vec%0d.pop", i), 64'(fifo_pop), 64'(vt[i].exp_pop));
      chk_out($sformatf("vec%0d", i), vt[i].exp_valid, vt[i].exp_pc, vt[i].exp_inst);
      advance();
    end

    // Stall: 5 cycles of out_ready=0 with more data queued.
    q.push_back(pkts[3]);
    q.push_back(pkts[0]);
    drive(1'b1, 1'b0, 1'b0);
    check("stall.load_pop", 64'(fifo_pop), 64'd1);
    advance();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      check($sformatf("stall%0d.pop", k), 64'(fifo_pop), 64'd0);
      chk_out($sformatf("stall%0d", k), 1'b1, 32'h1C000020, 32'h00000011);
      advance();
    end

    // Reset mid-stall: outputs and pop low, state and counters cleared.
    drive(1'b0, 1'b0, 1'b0);
`ifdef FETCH_UNPACKER_PERF_EN
    check("perf.stall5", 64'(perf_stall_cnt), 64'd5);
`endif
    check("rst0.pop", 64'(fifo_pop), 64'd0);
    chk_out("rst0", 1'b0, 32'h0, 32'h0);
    advance();
    drive(1'b0, 1'b0, 1'b1);
    check("rst1.pop", 64'(fifo_pop), 64'd0);
    chk_out("rst1", 1'b0, 32'h0, 32'h0);
`ifdef FETCH_UNPACKER_PERF_EN
    check("perf.stall_clr",  64'(perf_stall_cnt),  64'd0);
    check("perf.starve_clr", 64'(perf_starve_cnt), 64'd0);
`endif
    advance();

    // Back-to-back: three full packets, six consecutive issues.
    q.push_back(pkts[3]);
    q.push_back(pkts[4]);
    drive(1'b1, 1'b0, 1'b1);
    check("b2b.first_pop", 64'(fifo_pop), 64'd1);
    chk_out("b2b.pre", 1'b0, 32'h0, 32'h0);
    advance();
    begin
      logic [31:0] exp_pcs [6];
      exp_pcs = '{32'h1C000000, 32'h1C000004, 32'h1C000020, 32'h1C000024, 32'h1C000030, 32'h1C000034};
      for (int k = 0; k < 6; k++) begin
        drive(1'b1, 1'b0, 1'b1);
        check($sformatf("b2b%0d.valid", k), 64'(out_valid), 64'd1);
        check($sformatf("b2b%0d.pc", k),    64'(out_pc),    64'(exp_pcs[k]));
        check($sformatf("b2b%0d.pop", k),   64'(fifo_pop),  64'((k == 1 || k == 3) ? 1 : 0));
        advance();
      end
    end
    drive(1'b1, 1'b0, 1'b1);
    chk_out("b2b.drained", 1'b0, 32'h0, 32'h0);
    advance();

    // Flush while lane 0 held and FIFO non-empty.
    q.push_back(pkts[0]);
    q.push_back(pkts[3]);
    drive(1'b1, 1'b0, 1'b0);
    check("fl.load_pop", 64'(fifo_pop), 64'd1);
    advance();
    drive(1'b1, 1'b1, 1'b0);
    check("fl.flush_pop", 64'(fifo_pop), 64'd0);
    chk_out("fl.flush_cyc", 1'b1, 32'h1C000000, 32'h02800000);
    advance();
    drive(1'b1, 1'b0, 1'b1);
    check("fl.after_pop", 64'(fifo_pop), 64'd1);
    chk_out("fl.after", 1'b0, 32'h0, 32'h0);
    advance();
    drive(1'b1, 1'b0, 1'b1);
    chk_out("fl.resume0", 1'b1, 32'h1C000020, 32'h00000011);
    advance();
    drive(1'b1, 1'b0, 1'b1);
    chk_out("fl.resume1", 1'b1, 32'h1C000024, 32'h00000012);
    check("fl.resume1_pop", 64'(fifo_pop), 64'd0);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
